// File: rtl/regfile_writeback.sv
// regfile_writeback: write-side driver of the CPU register file.
// Buffers ALU and load results in a small FIFO. Drains one entry per cycle
// onto the register file write port. Reports per-register pending writes.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_dest/alu_data  ALU result handshake
//   mem_valid/mem_ready/mem_dest/mem_data  load result handshake (priority)
//   wb_hold                        stalls the drain
//   write_enable/reg_write/write_data      registered register-file write port
//   pending                        bit r set while a write to register r is in flight
//   count                          current FIFO occupancy
module regfile_writeback #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [ADDR_WIDTH-1:0]       alu_dest,
  input  logic [DATA_WIDTH-1:0]       alu_data,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic [ADDR_WIDTH-1:0]       mem_dest,
  input  logic [DATA_WIDTH-1:0]       mem_data,
  input  logic                        wb_hold,
  output logic                        write_enable,
  output logic [ADDR_WIDTH-1:0]       reg_write,
  output logic [DATA_WIDTH-1:0]       write_data,
  output logic [(2**ADDR_WIDTH)-1:0]  pending,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 2**ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] r_dest [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_reg_write;
  logic [DATA_WIDTH-1:0] r_write_data;

  logic                  w_not_full;
  logic                  w_mem_ready;
  logic                  w_alu_ready;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_push_dest;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic [NREG-1:0]       w_pending;

  // Handshake: load unit wins; full refuses both even if a pop is under way.
  assign w_not_full  = r_count < CNT_W'(DEPTH);
  assign w_mem_ready = !reset && w_not_full;
  assign w_alu_ready = !reset && w_not_full && !mem_valid;
  assign w_push      = (mem_valid && w_mem_ready) || (alu_valid && w_alu_ready);
  assign w_push_dest = mem_valid ? mem_dest : alu_dest;
  assign w_push_data = mem_valid ? mem_data : alu_data;
  assign w_pop       = !reset && !wb_hold && (r_count != '0);

  // Pending map: every live FIFO entry plus the write currently on the port.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      // Entry i is live when its distance from the head is below occupancy.
      if (CNT_W'(PTR_W'(PTR_W'(i) - r_rd_ptr)) < r_count) begin
        w_pending[r_dest[i]] = 1'b1;
      end
    end
    if (r_we) begin
      w_pending[r_reg_write] = 1'b1;
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_dest[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_dest[r_wr_ptr] <= w_push_dest;
        r_data[r_wr_ptr] <= w_push_data;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage: index and data hold their last values when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we         <= 1'b0;
      r_reg_write  <= '0;
      r_write_data <= '0;
    end else if (w_pop) begin
      r_we         <= 1'b1;
      r_reg_write  <= r_dest[r_rd_ptr];
      r_write_data <= r_data[r_rd_ptr];
    end else begin
      r_we         <= 1'b0;
    end
  end

  assign mem_ready    = w_mem_ready;
  assign alu_ready    = w_alu_ready;
  assign write_enable = r_we;
  assign reg_write    = r_reg_write;
  assign write_data   = r_write_data;
  assign pending      = w_pending;
  assign count        = r_count;

endmodule
